// File: rtl/fn_sw_seq.sv
// Bit-serial sequencer around a 1-bit AND/OR/XOR/XNOR unit: shifts operands LSB-first, collects y into a result.
// Latency: out_valid rises WIDTH cycles after the input handshake; one job per WIDTH+2 cycles at best.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
module fn_sw_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic             fn_a,
  output logic             fn_b,
  output logic [1:0]       fn_sel,
  input  logic             fn_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_ssel;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_out_fire;

  // in_ready is gated by reset so nothing is accepted while reset is held
  assign in_ready   = rst_n && (r_state == S_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt == CW'(WIDTH-1));
  assign w_out_fire = out_valid && out_ready;

  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign result     = r_result;
  // operand bits only reach the unit while shifting; select stays latched through DONE
  assign fn_a       = (r_state == S_SHIFT) && r_sa[0];
  assign fn_b       = (r_state == S_SHIFT) && r_sb[0];
  assign fn_sel     = (r_state == S_IDLE) ? 2'b00 : r_ssel;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state: accept -> WIDTH shift cycles -> hold until the result is taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next = S_SHIFT;
      S_SHIFT: if (w_last)     w_next = S_DONE;
      S_DONE:  if (w_out_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: latch job in IDLE, shift operands out and y in (MSB side) during SHIFT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_result <= '0;
      r_ssel   <= 2'b00;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sa   <= op_a;
            r_sb   <= op_b;
            r_ssel <= op_sel;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_result <= {fn_y, r_result[WIDTH-1:1]};
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fn_sw_seq.sv
module tb_fn_sw_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_sel;
  logic         fn_a;
  logic         fn_b;
  logic [1:0]   fn_sel;
  logic         fn_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fn_sw_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .fn_a(fn_a), .fn_b(fn_b), .fn_sel(fn_sel), .fn_y(fn_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  // the combinational logic unit the sequencer drives
  always_comb begin
    case (fn_sel)
      2'b00:   fn_y = fn_a & fn_b;
      2'b01:   fn_y = fn_a | fn_b;
      2'b10:   fn_y = fn_a ^ fn_b;
      default: fn_y = ~(fn_a ^ fn_b);
    endcase
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One job: handshake, watch SHIFT, optional stray in_valid pulse, optional DONE stall, output handshake.
  task automatic run_job(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] sel, input logic [W-1:0] exp,
                         input int hold, input int pulse_at);
    int n;
    int lat;
    logic sel_ok;
    logic busy_ok;
    logic stray_ok;
    @(negedge clk);
    op_a = a; op_b = b; op_sel = sel; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " accept"}, in_ready, 1);
    @(negedge clk);
    // scramble inputs after acceptance: latched values must be used
    in_valid = 1'b0; op_sel = ~sel; op_a = ~a; op_b = ~b;
    lat = 0; sel_ok = 1'b1; busy_ok = 1'b1; stray_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (fn_sel !== sel) sel_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == pulse_at) begin
        in_valid = 1'b1; op_a = 8'hFF; op_b = 8'h00; op_sel = 2'b00;
        if (in_ready !== 1'b0) stray_ok = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({name, " out_valid"}, out_valid, 1);
    check({name, " latency"}, lat, W);
    check({name, " fn_sel held in SHIFT"}, sel_ok, 1);
    check({name, " busy in SHIFT"}, busy_ok, 1);
    if (pulse_at >= 0) check({name, " in_ready low at stray pulse"}, stray_ok, 1);
    check({name, " result"}, result, exp);
    check({name, " DONE fn_a/fn_b/fn_sel"}, {fn_a, fn_b, fn_sel}, {2'b00, sel});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " stall out_valid"}, out_valid, 1);
      check({name, " stall result"}, result, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " after handshake out_valid/in_ready/busy"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int acc_cyc[3];
    int k_in;
    int k_out;
    int cyc;
    logic idle_ok;
    vec_t jobs[3];

    vecs[0] = '{a: 8'hF0, b: 8'h3C, sel: 2'b00, exp: 8'h30};
    vecs[1] = '{a: 8'hF0, b: 8'h3C, sel: 2'b01, exp: 8'hFC};
    vecs[2] = '{a: 8'hF0, b: 8'h3C, sel: 2'b10, exp: 8'hCC};
    vecs[3] = '{a: 8'hF0, b: 8'h3C, sel: 2'b11, exp: 8'h33};
    vecs[4] = '{a: 8'h96, b: 8'h69, sel: 2'b00, exp: 8'h00};
    vecs[5] = '{a: 8'h81, b: 8'h18, sel: 2'b01, exp: 8'h99};
    vecs[6] = '{a: 8'h5A, b: 8'hFF, sel: 2'b10, exp: 8'hA5};
    vecs[7] = '{a: 8'h01, b: 8'h80, sel: 2'b11, exp: 8'h7E};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sel = 2'b00;
    repeat (3) @(negedge clk);
    check("in_ready during reset", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("reset in_ready/out_valid/busy", {in_ready, out_valid, busy}, 3'b100);
    check("reset result", result, 0);
    check("reset fn_a/fn_b/fn_sel", {fn_a, fn_b, fn_sel}, 4'b0000);

    // out_ready outside DONE does nothing
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_ready in IDLE", {out_valid, busy, in_ready}, 3'b001);

    for (int i = 0; i < 8; i++)
      run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, 0, -1);

    // result held for 5 stalled cycles in DONE
    run_job("backpressure", 8'hF0, 8'h3C, 2'b00, 8'h30, 5, -1);

    // stray in_valid mid-SHIFT must be ignored and leave no second job behind
    run_job("stray pulse", 8'hAA, 8'h55, 2'b10, 8'hFF, 0, 3);
    idle_ok = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
    end
    check("no job from stray pulse", idle_ok, 1);

    // reset during SHIFT cycle 4 aborts the job
    @(negedge clk);
    op_a = 8'hF0; op_b = 8'h3C; op_sel = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy before mid reset", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid reset in_ready/out_valid/busy", {in_ready, out_valid, busy}, 3'b100);
    check("mid reset result", result, 0);
    run_job("after reset xnor", 8'h0F, 8'h0F, 2'b11, 8'hFF, 0, -1);

    // back-to-back: in_valid held, out_ready tied high
    jobs[0] = '{a: 8'hC3, b: 8'hA5, sel: 2'b00, exp: 8'h81};
    jobs[1] = '{a: 8'hC3, b: 8'hA5, sel: 2'b01, exp: 8'hE7};
    jobs[2] = '{a: 8'hC3, b: 8'hA5, sel: 2'b10, exp: 8'h66};
    k_in = 0; k_out = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    out_ready = 1'b1;
    while (k_out < 3 && cyc < 100) begin
      @(negedge clk);
      if (k_in < 3) begin
        in_valid = 1'b1;
        op_a = jobs[k_in].a; op_b = jobs[k_in].b; op_sel = jobs[k_in].sel;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check($sformatf("b2b result %0d", k_out), result, jobs[k_out].exp);
        k_out++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[k_in] = cyc;
        k_in++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b completed jobs", k_out, 3);
    check("b2b interval 0-1", acc_cyc[1] - acc_cyc[0], 10);
    check("b2b interval 1-2", acc_cyc[2] - acc_cyc[1], 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
